// File: rtl/pcs_sync_if.sv
// Code-group bus between the PMA/deserializer side and the PCS sync stage.
// loss_cnt exists only when PCS_SYNC_LOSS_CNT_EN is defined.
interface pcs_sync_if #(
  parameter int CNT_W = 8
);
  logic       signal_detect;
  logic [9:0] rx_code_group;
  logic [9:0] rx_code_group_o;
  logic       sync_status;
  logic       rx_even;
  logic       cgbad_o;
`ifdef PCS_SYNC_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_cnt;
`endif

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pcs_sync_if: CNT_W must be at least 1");
  end

  modport master (
    output signal_detect, rx_code_group,
`ifdef PCS_SYNC_LOSS_CNT_EN
    input  loss_cnt,
`endif
    input  rx_code_group_o, sync_status, rx_even, cgbad_o
  );

  modport slave (
    input  signal_detect, rx_code_group,
`ifdef PCS_SYNC_LOSS_CNT_EN
    output loss_cnt,
`endif
    output rx_code_group_o, sync_status, rx_even, cgbad_o
  );
endinterface

// File: rtl/pcs_sync.sv
// 1000BASE-X PCS code-group synchronization (clause 36 sync state machine).
// Optional saturating loss-of-sync counter enabled by PCS_SYNC_LOSS_CNT_EN.
module pcs_sync #(
  parameter int GOOD_CGS_MAX = 3,
  parameter int CNT_W        = 8
) (
  input logic        GTX_CLK,
  input logic        mr_main_reset,
  pcs_sync_if.slave  bus
);
  typedef enum logic [3:0] {
    LOSS_OF_SYNC, COMMA_DETECT_1, ACQUIRE_SYNC_1, COMMA_DETECT_2,
    ACQUIRE_SYNC_2, COMMA_DETECT_3, SYNC_ACQUIRED_1,
    SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A,
    SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A
  } state_t;

  localparam logic [1:0] GOOD_MAX = 2'(GOOD_CGS_MAX);

  state_t     state, next_state;
  logic [1:0] good_cgs, good_next;
  logic       rx_even_q, sync_q, cgbad_q;
  logic [9:0] cg_q;
  logic       comma, valid, is_k, is_d, cgbad;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pcs_sync: CNT_W must be at least 1");
  end

  // Both running-disparity columns are accepted; disparity itself is not tracked.
  always_comb begin
    is_k  = 1'b0;
    valid = 1'b0;
    case (bus.rx_code_group)
      10'b0011111010, 10'b1100000101,
      10'b1101101000, 10'b0010010111,
      10'b1011101000, 10'b0100010111,
      10'b1110101000, 10'b0001010111: begin
        is_k  = 1'b1;
        valid = 1'b1;
      end
      10'b1010010110,
      10'b0110110101, 10'b1001000101,
      10'b1001110100, 10'b0110001011,
      10'b0111010100, 10'b1000101011,
      10'b1011010100, 10'b0100101011,
      10'b1100011011, 10'b1100010100,
      10'b1101010100, 10'b0010101011,
      10'b1010011011, 10'b1010010100,
      10'b0110011011, 10'b0110010100,
      10'b1110001011, 10'b0001110100: valid = 1'b1;
      default: valid = 1'b0;
    endcase
    comma = (bus.rx_code_group[9:3] == 7'b0011111) ||
            (bus.rx_code_group[9:3] == 7'b1100000);
    is_d  = valid && !is_k;
    cgbad = !valid || (comma && rx_even_q);
  end

  always_comb begin
    next_state = LOSS_OF_SYNC;
    good_next  = good_cgs;
    case (state)
      LOSS_OF_SYNC:   next_state = (valid && comma) ? COMMA_DETECT_1 : LOSS_OF_SYNC;
      COMMA_DETECT_1: next_state = is_d ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
      ACQUIRE_SYNC_1:
        if (cgbad)                      next_state = LOSS_OF_SYNC;
        else if (comma && !rx_even_q)   next_state = COMMA_DETECT_2;
        else                            next_state = ACQUIRE_SYNC_1;
      COMMA_DETECT_2: next_state = is_d ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
      ACQUIRE_SYNC_2:
        if (cgbad)                      next_state = LOSS_OF_SYNC;
        else if (comma && !rx_even_q)   next_state = COMMA_DETECT_3;
        else                            next_state = ACQUIRE_SYNC_2;
      COMMA_DETECT_3: next_state = is_d ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
      SYNC_ACQUIRED_1: begin
        next_state = cgbad ? SYNC_ACQUIRED_2 : SYNC_ACQUIRED_1;
        good_next  = 2'd0;
      end
      SYNC_ACQUIRED_2:
        if (cgbad) begin next_state = SYNC_ACQUIRED_3;  good_next = 2'd0; end
        else       begin next_state = SYNC_ACQUIRED_2A; good_next = 2'd1; end
      SYNC_ACQUIRED_3:
        if (cgbad) begin next_state = SYNC_ACQUIRED_4;  good_next = 2'd0; end
        else       begin next_state = SYNC_ACQUIRED_3A; good_next = 2'd1; end
      SYNC_ACQUIRED_4:
        if (cgbad) begin next_state = LOSS_OF_SYNC;     good_next = 2'd0; end
        else       begin next_state = SYNC_ACQUIRED_4A; good_next = 2'd1; end
      // Recovery states: the good count is compared before it is bumped.
      SYNC_ACQUIRED_2A:
        if (cgbad)                       begin next_state = SYNC_ACQUIRED_3;  good_next = 2'd0; end
        else if (good_cgs == GOOD_MAX)   begin next_state = SYNC_ACQUIRED_1;  good_next = 2'd0; end
        else begin
          next_state = SYNC_ACQUIRED_2A;
          if (good_cgs != 2'd3) good_next = good_cgs + 2'd1;
        end
      SYNC_ACQUIRED_3A:
        if (cgbad)                       begin next_state = SYNC_ACQUIRED_4;  good_next = 2'd0; end
        else if (good_cgs == GOOD_MAX)   begin next_state = SYNC_ACQUIRED_2;  good_next = 2'd0; end
        else begin
          next_state = SYNC_ACQUIRED_3A;
          if (good_cgs != 2'd3) good_next = good_cgs + 2'd1;
        end
      SYNC_ACQUIRED_4A:
        if (cgbad)                       begin next_state = LOSS_OF_SYNC;     good_next = 2'd0; end
        else if (good_cgs == GOOD_MAX)   begin next_state = SYNC_ACQUIRED_3;  good_next = 2'd0; end
        else begin
          next_state = SYNC_ACQUIRED_4A;
          if (good_cgs != 2'd3) good_next = good_cgs + 2'd1;
        end
      default: next_state = LOSS_OF_SYNC;
    endcase
    if (!bus.signal_detect) begin
      next_state = LOSS_OF_SYNC;
      good_next  = 2'd0;
    end
  end

  always_ff @(posedge GTX_CLK) begin
    if (mr_main_reset) begin
      state     <= LOSS_OF_SYNC;
      good_cgs  <= 2'd0;
      rx_even_q <= 1'b0;
      sync_q    <= 1'b0;
      cgbad_q   <= 1'b0;
      cg_q      <= 10'd0;
    end else begin
      state     <= next_state;
      good_cgs  <= good_next;
      rx_even_q <= (next_state inside {COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3})
                   ? 1'b1 : ~rx_even_q;
      sync_q    <= next_state inside {SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
                                      SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A,
                                      SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A};
      cgbad_q   <= cgbad;
      cg_q      <= bus.rx_code_group;
    end
  end

  assign bus.rx_code_group_o = cg_q;
  assign bus.sync_status     = sync_q;
  assign bus.rx_even         = rx_even_q;
  assign bus.cgbad_o         = cgbad_q;

`ifdef PCS_SYNC_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_q;
  logic             in_sync;

  assign in_sync = state inside {SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
                                 SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A,
                                 SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A};

  always_ff @(posedge GTX_CLK) begin
    if (mr_main_reset)
      loss_q <= '0;
    else if (in_sync && next_state == LOSS_OF_SYNC && loss_q != {CNT_W{1'b1}})
      loss_q <= loss_q + 1'b1;
  end

  assign bus.loss_cnt = loss_q;
`endif
endmodule
